// File: rtl/busytable_mp.sv
// busytable_mp: parametrised physical-register busy table with ROB-recovery FSM.
// Optional speculative load wakeup is built when BUSYTABLE_SPEC_WAKE_EN is defined.
`ifndef ROB_STATE_IDLE
`define ROB_STATE_IDLE          2'd0
`endif
`ifndef ROB_STATE_OVERWRITE_RAT
`define ROB_STATE_OVERWRITE_RAT 2'd1
`endif
`ifndef ROB_STATE_WALKING
`define ROB_STATE_WALKING       2'd2
`endif

module busytable_mp_chk #(
    parameter int PREG_NUM    = 64,
    parameter int PREG_W      = 6,
    parameter int RD_PORTS    = 4,
    parameter int ALLOC_PORTS = 2,
    parameter int WB_PORTS    = 2,
    parameter int WALK_PORTS  = 2
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [RD_PORTS*PREG_W-1:0]    rd_addr,
    input  logic [ALLOC_PORTS-1:0]        alloc_en,
    input  logic [ALLOC_PORTS*PREG_W-1:0] alloc_addr,
    input  logic [WB_PORTS-1:0]           wb_en,
    input  logic [WB_PORTS*PREG_W-1:0]    wb_addr,
    input  logic [WALK_PORTS-1:0]         walk_valid,
    input  logic [WALK_PORTS*PREG_W-1:0]  walk_prd,
    input  logic                          spec_wk_en,
    input  logic [PREG_W-1:0]             spec_wk_addr
);
    function automatic logic idx_ok_f(input logic [PREG_W-1:0] a);
        return (int'(a) < PREG_NUM);
    endfunction

    // Every used preg index must name an existing register
    always @(posedge clock) begin
        if (reset_n) begin
            for (int i = 0; i < RD_PORTS; i++)
                assert (idx_ok_f(rd_addr[i*PREG_W +: PREG_W]));
            for (int i = 0; i < ALLOC_PORTS; i++)
                assert (!alloc_en[i] || idx_ok_f(alloc_addr[i*PREG_W +: PREG_W]));
            for (int i = 0; i < WB_PORTS; i++)
                assert (!wb_en[i] || idx_ok_f(wb_addr[i*PREG_W +: PREG_W]));
            for (int i = 0; i < WALK_PORTS; i++)
                assert (!walk_valid[i] || idx_ok_f(walk_prd[i*PREG_W +: PREG_W]));
            assert (!spec_wk_en || idx_ok_f(spec_wk_addr));
        end
    end
endmodule

module busytable_mp #(
    parameter int PREG_NUM    = 64,
    parameter int PREG_W      = 6,
    parameter int RD_PORTS    = 4,
    parameter int ALLOC_PORTS = 2,
    parameter int WB_PORTS    = 2,
    parameter int WALK_PORTS  = 2,
    parameter int SPEC_DLY    = 2
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [RD_PORTS*PREG_W-1:0]    rd_addr,
    output logic [RD_PORTS-1:0]           rd_busy,
    input  logic [ALLOC_PORTS-1:0]        alloc_en,
    input  logic [ALLOC_PORTS*PREG_W-1:0] alloc_addr,
    input  logic [WB_PORTS-1:0]           wb_en,
    input  logic [WB_PORTS*PREG_W-1:0]    wb_addr,
    input  logic [WALK_PORTS-1:0]         walk_valid,
    input  logic [WALK_PORTS-1:0]         walk_cmpl,
    input  logic [WALK_PORTS*PREG_W-1:0]  walk_prd,
    input  logic [1:0]                    rob_state,
    input  logic                          spec_wk_en,
    input  logic [PREG_W-1:0]             spec_wk_addr,
    input  logic                          spec_cancel,
    output logic                          bt_recover
);
    typedef enum logic [1:0] {ST_RUN = 2'd0, ST_CLR = 2'd1, ST_WALK = 2'd2} bt_state_e;

    bt_state_e           state_r, state_nxt_s;
    logic [PREG_NUM-1:0] busy_r, busy_nxt_s, set_s, clr_s, spec_set_s, spec_clr_s;
    logic                bt_recover_r;
    logic                spec_byp_en_s;
    logic [PREG_W-1:0]   spec_byp_addr_s;
    logic [RD_PORTS-1:0] rd_busy_s;

    function automatic logic wb_hit_f(input logic [PREG_W-1:0] a,
                                      input logic [WB_PORTS-1:0] en,
                                      input logic [WB_PORTS*PREG_W-1:0] addrs);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < WB_PORTS; i++)
            hit = hit | (en[i] & (addrs[i*PREG_W +: PREG_W] == a));
        return hit;
    endfunction

    // Recovery FSM next-state from registered state and ROB state
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (rob_state == `ROB_STATE_OVERWRITE_RAT) state_nxt_s = ST_CLR;
                else                                       state_nxt_s = ST_RUN;
            end
            ST_CLR: begin
                case (rob_state)
                    `ROB_STATE_WALKING: state_nxt_s = ST_WALK;
                    `ROB_STATE_IDLE:    state_nxt_s = ST_RUN;
                    default:            state_nxt_s = ST_CLR;
                endcase
            end
            ST_WALK: begin
                case (rob_state)
                    `ROB_STATE_IDLE:          state_nxt_s = ST_RUN;
                    `ROB_STATE_OVERWRITE_RAT: state_nxt_s = ST_CLR;
                    default:                  state_nxt_s = ST_WALK;
                endcase
            end
            default: state_nxt_s = ST_RUN;
        endcase
    end

`ifdef BUSYTABLE_SPEC_WAKE_EN
    logic [SPEC_DLY-1:0]        sp_vld_r, sp_live_s;
    logic [SPEC_DLY*PREG_W-1:0] sp_addr_r;
    logic                       push_s, push_live_s;

    // Spec wakeup clears now; cancel re-sets every still-live entry, including the one being pushed
    always_comb begin
        push_s          = spec_wk_en & (state_r == ST_RUN);
        push_live_s     = push_s & ~wb_hit_f(spec_wk_addr, wb_en, wb_addr);
        spec_set_s      = '0;
        spec_clr_s      = '0;
        spec_clr_s[spec_wk_addr] = push_s;
        spec_set_s[spec_wk_addr] = push_live_s & spec_cancel;
        for (int i = 0; i < SPEC_DLY; i++) begin
            sp_live_s[i] = sp_vld_r[i] & ~wb_hit_f(sp_addr_r[i*PREG_W +: PREG_W], wb_en, wb_addr);
            spec_set_s[sp_addr_r[i*PREG_W +: PREG_W]] =
                spec_set_s[sp_addr_r[i*PREG_W +: PREG_W]] | (sp_live_s[i] & spec_cancel);
        end
        spec_byp_en_s   = push_s;
        spec_byp_addr_s = spec_wk_addr;
    end

    // Confirm shift pipe; emptied by cancel or while the table is being cleared
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sp_vld_r  <= '0;
            sp_addr_r <= '0;
        end else if ((state_r == ST_CLR) || spec_cancel) begin
            sp_vld_r  <= '0;
        end else begin
            sp_vld_r[0]             <= push_live_s;
            sp_addr_r[0 +: PREG_W]  <= spec_wk_addr;
            for (int i = 1; i < SPEC_DLY; i++) begin
                sp_vld_r[i]                   <= sp_live_s[i-1];
                sp_addr_r[i*PREG_W +: PREG_W] <= sp_addr_r[(i-1)*PREG_W +: PREG_W];
            end
        end
    end
`else
    localparam int spec_dly_unused = SPEC_DLY;
    logic spec_ports_unused_s;

    // Speculative wakeup not built: ports are sunk, no contribution to the table
    always_comb begin
        spec_ports_unused_s = ^{spec_wk_en, spec_wk_addr, spec_cancel};
        spec_set_s          = '0;
        spec_clr_s          = '0;
        spec_byp_en_s       = 1'b0;
        spec_byp_addr_s     = '0;
    end
`endif

    // Per-state set/clear masks; sets take priority when merged below
    always_comb begin
        set_s = spec_set_s;
        clr_s = spec_clr_s;
        for (int i = 0; i < ALLOC_PORTS; i++)
            set_s[alloc_addr[i*PREG_W +: PREG_W]] = set_s[alloc_addr[i*PREG_W +: PREG_W]]
                | (alloc_en[i] & (state_r == ST_RUN));
        for (int i = 0; i < WALK_PORTS; i++)
            set_s[walk_prd[i*PREG_W +: PREG_W]] = set_s[walk_prd[i*PREG_W +: PREG_W]]
                | (walk_valid[i] & ~walk_cmpl[i] & (state_r == ST_WALK));
        for (int i = 0; i < WB_PORTS; i++)
            clr_s[wb_addr[i*PREG_W +: PREG_W]] = clr_s[wb_addr[i*PREG_W +: PREG_W]] | wb_en[i];
    end

    // Next busy vector
    always_comb begin
        case (state_r)
            ST_RUN, ST_WALK: busy_nxt_s = (busy_r & ~clr_s) | set_s;
            ST_CLR:          busy_nxt_s = '0;
            default:         busy_nxt_s = '0;
        endcase
    end

    // Zero-latency lookup with writeback and spec-wakeup bypass; alloc intentionally not bypassed
    always_comb begin
        for (int i = 0; i < RD_PORTS; i++)
            rd_busy_s[i] = busy_r[rd_addr[i*PREG_W +: PREG_W]]
                & ~wb_hit_f(rd_addr[i*PREG_W +: PREG_W], wb_en, wb_addr)
                & ~(spec_byp_en_s & (spec_byp_addr_s == rd_addr[i*PREG_W +: PREG_W]))
                & (state_r != ST_CLR);
    end

    // State, table and recovery flag registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_RUN;
            busy_r       <= '0;
            bt_recover_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            busy_r       <= busy_nxt_s;
            bt_recover_r <= (state_nxt_s != ST_RUN);
        end
    end

    assign rd_busy    = rd_busy_s;
    assign bt_recover = bt_recover_r;

    busytable_mp_chk #(
        .PREG_NUM(PREG_NUM), .PREG_W(PREG_W), .RD_PORTS(RD_PORTS),
        .ALLOC_PORTS(ALLOC_PORTS), .WB_PORTS(WB_PORTS), .WALK_PORTS(WALK_PORTS)
    ) u_chk (
        .clock(clock), .reset_n(reset_n), .rd_addr(rd_addr),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr),
        .wb_en(wb_en), .wb_addr(wb_addr),
        .walk_valid(walk_valid), .walk_prd(walk_prd),
        .spec_wk_en(spec_wk_en), .spec_wk_addr(spec_wk_addr)
    );
endmodule

// File: tb/tb_busytable_mp.sv
// Directed self-checking bench for busytable_mp (default parameters, SPEC_DLY=2).
module tb_busytable_mp;
    localparam int PW = 6;

    logic          clock = 1'b0;
    logic          reset_n;
    logic [4*PW-1:0] rd_addr;
    logic [3:0]    rd_busy;
    logic [1:0]    alloc_en;
    logic [2*PW-1:0] alloc_addr;
    logic [1:0]    wb_en;
    logic [2*PW-1:0] wb_addr;
    logic [1:0]    walk_valid;
    logic [1:0]    walk_cmpl;
    logic [2*PW-1:0] walk_prd;
    logic [1:0]    rob_state;
    logic          spec_wk_en;
    logic [PW-1:0] spec_wk_addr;
    logic          spec_cancel;
    logic          bt_recover;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    busytable_mp dut (
        .clock(clock), .reset_n(reset_n),
        .rd_addr(rd_addr), .rd_busy(rd_busy),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr),
        .wb_en(wb_en), .wb_addr(wb_addr),
        .walk_valid(walk_valid), .walk_cmpl(walk_cmpl), .walk_prd(walk_prd),
        .rob_state(rob_state),
        .spec_wk_en(spec_wk_en), .spec_wk_addr(spec_wk_addr), .spec_cancel(spec_cancel),
        .bt_recover(bt_recover)
    );

    task automatic idle_inputs();
        alloc_en = 2'b00; alloc_addr = '0;
        wb_en = 2'b00; wb_addr = '0;
        walk_valid = 2'b00; walk_cmpl = 2'b00; walk_prd = '0;
        rob_state = 2'd0;
        spec_wk_en = 1'b0; spec_wk_addr = '0; spec_cancel = 1'b0;
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_rd(input int p0, input int p1, input int p2, input int p3);
        rd_addr = {PW'(p3), PW'(p2), PW'(p1), PW'(p0)};
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle_inputs();
        set_rd(0, 1, 2, 3);
        #2;
        n_tests++;
        if (rd_busy !== 4'b0000) begin n_fail++; $display("FAIL reset_rd_busy: got %b exp 0000", rd_busy); end
        n_tests++;
        if (bt_recover !== 1'b0) begin n_fail++; $display("FAIL reset_bt_recover: got %b exp 0", bt_recover); end
        step();
        reset_n = 1'b1;
        step();
        // T1: alloc p5 then reset mid-cycle
        alloc_en = 2'b01; alloc_addr = {PW'(0), PW'(5)};
        step();
        alloc_en = 2'b00;
        set_rd(5, 0, 0, 0);
        #2;
        n_tests++;
        if (rd_busy[0] !== 1'b1) begin n_fail++; $display("FAIL t1_busy_before: got %b exp 1", rd_busy[0]); end
        reset_n = 1'b0;
        #1;
        n_tests++;
        if (rd_busy[0] !== 1'b0) begin n_fail++; $display("FAIL t1_async_clear: got %b exp 0", rd_busy[0]); end
        step();
        reset_n = 1'b1;
        #2;
        n_tests++;
        if (rd_busy[0] !== 1'b0) begin n_fail++; $display("FAIL t1_after_release: got %b exp 0", rd_busy[0]); end
    endtask

    task automatic test_alloc_wb();
        step();
        alloc_en = 2'b01; alloc_addr = {PW'(0), PW'(7)};
        set_rd(7, 9, 0, 0);
        step();
        alloc_en = 2'b00;
        #2;
        n_tests++;
        if (rd_busy[0] !== 1'b1) begin n_fail++; $display("FAIL t2_c1: got %b exp 1", rd_busy[0]); end
        step();
        #2;
        n_tests++;
        if (rd_busy[0] !== 1'b1) begin n_fail++; $display("FAIL t2_c2: got %b exp 1", rd_busy[0]); end
        step();
        wb_en = 2'b01; wb_addr = {PW'(0), PW'(7)};
        #2;
        n_tests++;
        if (rd_busy[0] !== 1'b0) begin n_fail++; $display("FAIL t2_c3_bypass: got %b exp 0", rd_busy[0]); end
        step();
        wb_en = 2'b00;
        #2;
        n_tests++;
        if (rd_busy[0] !== 1'b0) begin n_fail++; $display("FAIL t2_c4: got %b exp 0", rd_busy[0]); end
        // alloc and wb of p9 in the same cycle: set wins; duplicated alloc on both ports is idempotent
        step();
        alloc_en = 2'b11; alloc_addr = {PW'(9), PW'(9)};
        wb_en = 2'b10; wb_addr = {PW'(9), PW'(0)};
        step();
        idle_inputs();
        #2;
        n_tests++;
        if (rd_busy[1] !== 1'b1) begin n_fail++; $display("FAIL t2_set_wins: got %b exp 1", rd_busy[1]); end
    endtask

    task automatic test_multi_read();
        step();
        alloc_en = 2'b11; alloc_addr = {PW'(1), PW'(0)};
        step();
        alloc_addr = {PW'(3), PW'(2)};
        step();
        alloc_en = 2'b00;
        set_rd(0, 1, 2, 3);
        wb_en = 2'b11; wb_addr = {PW'(3), PW'(1)};
        #2;
        n_tests++;
        if (rd_busy !== 4'b0101) begin n_fail++; $display("FAIL t6_wb_bypass: got %b exp 0101", rd_busy); end
        step();
        wb_en = 2'b00;
        #2;
        n_tests++;
        if (rd_busy !== 4'b0101) begin n_fail++; $display("FAIL t6_after_wb: got %b exp 0101", rd_busy); end
    endtask

    task automatic test_recovery();
        // p0, p2, p9 busy before recovery
        step();
        rob_state = 2'd1;
        set_rd(3, 4, 9, 30);
        #2;
        n_tests++;
        if (bt_recover !== 1'b0) begin n_fail++; $display("FAIL t3_run_flag: got %b exp 0", bt_recover); end
        n_tests++;
        if (rd_busy !== 4'b0100) begin n_fail++; $display("FAIL t3_pre_read: got %b exp 0100", rd_busy); end
        step();
        alloc_en = 2'b01; alloc_addr = {PW'(0), PW'(30)};
        #2;
        n_tests++;
        if (bt_recover !== 1'b1) begin n_fail++; $display("FAIL t3_clr_flag: got %b exp 1", bt_recover); end
        n_tests++;
        if (rd_busy !== 4'b0000) begin n_fail++; $display("FAIL t3_clr_read: got %b exp 0000", rd_busy); end
        step();
        rob_state = 2'd2;
        step();
        walk_valid = 2'b11; walk_cmpl = 2'b10; walk_prd = {PW'(4), PW'(3)};
        #2;
        n_tests++;
        if (bt_recover !== 1'b1) begin n_fail++; $display("FAIL t3_walk_flag: got %b exp 1", bt_recover); end
        n_tests++;
        if (rd_busy !== 4'b0000) begin n_fail++; $display("FAIL t3_walk_read: got %b exp 0000", rd_busy); end
        step();
        rob_state = 2'd0;
        walk_valid = 2'b00;
        alloc_en = 2'b00;
        #2;
        n_tests++;
        if (rd_busy !== 4'b0001) begin n_fail++; $display("FAIL t3_walk_set: got %b exp 0001", rd_busy); end
        step();
        #2;
        n_tests++;
        if (bt_recover !== 1'b0) begin n_fail++; $display("FAIL t3_back_run: got %b exp 0", bt_recover); end
        n_tests++;
        if (rd_busy !== 4'b0001) begin n_fail++; $display("FAIL t3_final: got %b exp 0001", rd_busy); end
    endtask

`ifdef BUSYTABLE_SPEC_WAKE_EN
    task automatic test_spec_cancel();
        step();
        alloc_en = 2'b11; alloc_addr = {PW'(20), PW'(12)};
        step();
        alloc_addr = {PW'(22), PW'(21)};
        step();
        alloc_en = 2'b00;
        set_rd(12, 20, 21, 22);
        #2;
        n_tests++;
        if (rd_busy[0] !== 1'b1) begin n_fail++; $display("FAIL t4_before: got %b exp 1", rd_busy[0]); end
        step();
        spec_wk_en = 1'b1; spec_wk_addr = PW'(12);
        #2;
        n_tests++;
        if (rd_busy[0] !== 1'b0) begin n_fail++; $display("FAIL t4_bypass: got %b exp 0", rd_busy[0]); end
        step();
        spec_wk_en = 1'b0; spec_cancel = 1'b1;
        #2;
        n_tests++;
        if (rd_busy[0] !== 1'b0) begin n_fail++; $display("FAIL t4_woken: got %b exp 0", rd_busy[0]); end
        step();
        spec_cancel = 1'b0;
        #2;
        n_tests++;
        if (rd_busy[0] !== 1'b1) begin n_fail++; $display("FAIL t4_cancel_reset: got %b exp 1", rd_busy[0]); end
        // push and cancel of p22 in the same cycle re-sets it
        step();
        spec_wk_en = 1'b1; spec_wk_addr = PW'(22); spec_cancel = 1'b1;
        step();
        spec_wk_en = 1'b0; spec_cancel = 1'b0;
        #2;
        n_tests++;
        if (rd_busy[3] !== 1'b1) begin n_fail++; $display("FAIL t4_push_cancel: got %b exp 1", rd_busy[3]); end
    endtask

    task automatic test_spec_wb_confirm();
        step();
        spec_wk_en = 1'b1; spec_wk_addr = PW'(20);
        step();
        spec_wk_en = 1'b0;
        wb_en = 2'b01; wb_addr = {PW'(0), PW'(20)};
        step();
        wb_en = 2'b00; spec_cancel = 1'b1;
        step();
        spec_cancel = 1'b0;
        #2;
        n_tests++;
        if (rd_busy[1] !== 1'b0) begin n_fail++; $display("FAIL t5_wb_invalidates: got %b exp 0", rd_busy[1]); end
        step();
        spec_wk_en = 1'b1; spec_wk_addr = PW'(21);
        step();
        spec_wk_en = 1'b0;
        step();
        step();
        spec_cancel = 1'b1;
        step();
        spec_cancel = 1'b0;
        #2;
        n_tests++;
        if (rd_busy[2] !== 1'b0) begin n_fail++; $display("FAIL t5_confirmed: got %b exp 0", rd_busy[2]); end
    endtask
`else
    task automatic test_spec_ignored();
        step();
        alloc_en = 2'b01; alloc_addr = {PW'(0), PW'(12)};
        step();
        alloc_en = 2'b00;
        set_rd(12, 0, 0, 0);
        spec_wk_en = 1'b1; spec_wk_addr = PW'(12);
        #2;
        n_tests++;
        if (rd_busy[0] !== 1'b1) begin n_fail++; $display("FAIL spec_no_bypass: got %b exp 1", rd_busy[0]); end
        step();
        spec_wk_en = 1'b0; spec_cancel = 1'b1;
        #2;
        n_tests++;
        if (rd_busy[0] !== 1'b1) begin n_fail++; $display("FAIL spec_no_clear: got %b exp 1", rd_busy[0]); end
        step();
        spec_cancel = 1'b0;
    endtask
`endif

    initial begin
        rd_addr = '0;
        test_reset();
        test_alloc_wb();
        test_multi_read();
        test_recovery();
`ifdef BUSYTABLE_SPEC_WAKE_EN
        test_spec_cancel();
        test_spec_wb_confirm();
`else
        test_spec_ignored();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
